// File: rtl/data_memory_bus.sv
// Handshaked byte-addressed data memory with wait states, sub-word access and
// post-reset fill of every word with INIT_VALUE.
module data_memory_bus #(
    parameter int          DEPTH       = 64,
    parameter int          WAIT_STATES = 1,
    parameter logic [31:0] INIT_VALUE  = 32'h00000001
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        init_done
);

    // state | meaning
    // INIT  | writing INIT_VALUE to word init_idx, one word per cycle
    // IDLE  | ready for a request
    // BUSY  | wait states counting down; access on the edge where the count is 0
    // RESP  | one-cycle response pulse
    localparam int AW = $clog2(DEPTH);
    localparam int CW = (WAIT_STATES > 0) ? $clog2(WAIT_STATES + 1) : 1;

    typedef enum logic [1:0] {S_INIT, S_IDLE, S_BUSY, S_RESP} state_t;
    state_t state, state_nxt;

    logic [31:0]   mem [DEPTH];
    logic [AW-1:0] init_idx;
    logic [CW-1:0] wait_cnt;
    logic          lat_we;
    logic [1:0]    lat_size;
    logic          lat_uns;
    logic [31:0]   lat_addr;
    logic [31:0]   lat_wdata;

    logic          init_last;
    logic          access;
    logic          acc_err;
    logic [AW-1:0] word_idx;
    logic [1:0]    lane;
    logic [3:0]    be;
    logic [31:0]   wr_data;
    logic [31:0]   rd_word;
    logic [7:0]    ld_byte;
    logic [15:0]   ld_half;
    logic [31:0]   ld_data;

    assign init_last = (init_idx == AW'(DEPTH - 1));
    assign access    = (state == S_BUSY) && (wait_cnt == '0);
    assign word_idx  = lat_addr[AW+1:2];
    assign lane      = lat_addr[1:0];

    always_ff @(posedge clk) begin
        if (rst) state <= S_INIT;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_INIT: if (init_last) state_nxt = S_IDLE;
            S_IDLE: if (req_valid) state_nxt = S_BUSY;
            S_BUSY: if (wait_cnt == '0) state_nxt = S_RESP;
            S_RESP: state_nxt = S_IDLE;
            default: state_nxt = S_INIT;
        endcase
    end

    always_comb begin
        req_ready  = (state == S_IDLE);
        resp_valid = (state == S_RESP);
    end

    always_comb begin
        acc_err = 1'b0;
        case (lat_size)
            2'b00:   acc_err = 1'b0;
            2'b01:   acc_err = lane[0];
            2'b10:   acc_err = (lane != 2'b00);
            default: acc_err = 1'b1;
        endcase
        if (lat_addr[31:2] >= 30'(DEPTH)) acc_err = 1'b1;
    end

    // Store data is replicated across lanes so the byte enables alone pick the target.
    always_comb begin
        be      = 4'b0000;
        wr_data = lat_wdata;
        case (lat_size)
            2'b00: begin
                be      = 4'b0001 << lane;
                wr_data = {4{lat_wdata[7:0]}};
            end
            2'b01: begin
                be      = lane[1] ? 4'b1100 : 4'b0011;
                wr_data = {2{lat_wdata[15:0]}};
            end
            2'b10:   be = 4'b1111;
            default: be = 4'b0000;
        endcase
    end

    always_comb begin
        rd_word = mem[word_idx];
        ld_byte = rd_word[{lane, 3'b000} +: 8];
        ld_half = lane[1] ? rd_word[31:16] : rd_word[15:0];
        case (lat_size)
            2'b00:   ld_data = lat_uns ? {24'b0, ld_byte} : {{24{ld_byte[7]}}, ld_byte};
            2'b01:   ld_data = lat_uns ? {16'b0, ld_half} : {{16{ld_half[15]}}, ld_half};
            default: ld_data = rd_word;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state == S_INIT) begin
                mem[init_idx] <= INIT_VALUE;
            end else if (access && lat_we && !acc_err) begin
                for (int b = 0; b < 4; b++) begin
                    if (be[b]) mem[word_idx][8*b +: 8] <= wr_data[8*b +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            init_idx   <= '0;
            wait_cnt   <= '0;
            init_done  <= 1'b0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
            lat_we     <= 1'b0;
            lat_size   <= 2'b00;
            lat_uns    <= 1'b0;
            lat_addr   <= '0;
            lat_wdata  <= '0;
        end else begin
            if (state == S_INIT) begin
                init_idx <= init_last ? '0 : init_idx + 1'b1;
                if (init_last) init_done <= 1'b1;
            end
            if (state == S_IDLE && req_valid) begin
                lat_we    <= req_we;
                lat_size  <= req_size;
                lat_uns   <= req_unsigned;
                lat_addr  <= req_addr;
                lat_wdata <= req_wdata;
                wait_cnt  <= CW'(WAIT_STATES);
            end
            if (state == S_BUSY && wait_cnt != '0) wait_cnt <= wait_cnt - 1'b1;
            if (access) begin
                resp_err   <= acc_err;
                resp_rdata <= (lat_we || acc_err) ? 32'h0 : ld_data;
            end
        end
    end

endmodule

// File: tb/tb_data_memory_bus.sv
// Bench for data_memory_bus: two instances (WAIT_STATES=1 and 0) share stimulus;
// directed vector table, reset corner sequences and random accesses vs a byte-array model.
module tb_data_memory_bus;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_we = 1'b0;
    logic [1:0]  req_size = 2'b00;
    logic        req_unsigned = 1'b0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;

    logic        req_ready_a, resp_valid_a, resp_err_a, init_done_a;
    logic [31:0] resp_rdata_a;
    logic        req_ready_b, resp_valid_b, resp_err_b, init_done_b;
    logic [31:0] resp_rdata_b;

    int checks = 0;
    int errors = 0;
    byte unsigned ref_mem [256];

    data_memory_bus #(.DEPTH(64), .WAIT_STATES(1), .INIT_VALUE(32'h00000001)) dut_a (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready_a),
        .req_we(req_we), .req_size(req_size), .req_unsigned(req_unsigned),
        .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(resp_valid_a),
        .resp_rdata(resp_rdata_a), .resp_err(resp_err_a), .init_done(init_done_a));

    data_memory_bus #(.DEPTH(64), .WAIT_STATES(0), .INIT_VALUE(32'h00000001)) dut_b (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready_b),
        .req_we(req_we), .req_size(req_size), .req_unsigned(req_unsigned),
        .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(resp_valid_b),
        .resp_rdata(resp_rdata_b), .resp_err(resp_err_b), .init_done(init_done_b));

    typedef struct {
        logic        we;
        logic [1:0]  size;
        logic        uns;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        err;
        logic [31:0] rdata;
    } vec_t;

    vec_t vq[$];

    function automatic vec_t mk(input logic we, input logic [1:0] size, input logic uns,
                                input logic [31:0] addr, input logic [31:0] wdata,
                                input logic err, input logic [31:0] rdata);
        vec_t v;
        v.we = we; v.size = size; v.uns = uns; v.addr = addr;
        v.wdata = wdata; v.err = err; v.rdata = rdata;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        checks++;
        errors++;
        $display("FAIL %s: timed out", name);
    endtask

    function automatic void model_init();
        for (int i = 0; i < 256; i++) ref_mem[i] = (i % 4 == 0) ? 8'h01 : 8'h00;
    endfunction

    // Little-endian byte array; errors leave it untouched and return 0.
    function automatic void model(input logic we, input logic [1:0] size, input logic uns,
                                  input logic [31:0] addr, input logic [31:0] wdata,
                                  output logic err, output logic [31:0] rdata);
        int n;
        logic [31:0] v;
        err = (size == 2'd3) || (size == 2'd1 && addr[0]) ||
              (size == 2'd2 && addr[1:0] != 2'b00) || (addr >= 32'd256);
        rdata = '0;
        if (err) return;
        n = 1 << size;
        if (we) begin
            for (int i = 0; i < n; i++) ref_mem[addr + i] = wdata[8*i +: 8];
        end else begin
            v = '0;
            for (int i = 0; i < n; i++) v = v | (32'(ref_mem[addr + i]) << (8*i));
            if (!uns && n < 4 && v[8*n-1]) v = v - (32'd1 << (8*n));
            rdata = v;
        end
    endfunction

    task automatic reset_and_init(input string tag);
        int n;
        rst = 1'b1;
        req_valid = 1'b0;
        repeat (2) begin
            @(posedge clk); #1;
            chk({tag, "_rst_outputs_a"},
                {27'b0, req_ready_a, resp_valid_a, resp_err_a, init_done_a, |resp_rdata_a}, '0);
            chk({tag, "_rst_outputs_b"},
                {27'b0, req_ready_b, resp_valid_b, resp_err_b, init_done_b, |resp_rdata_b}, '0);
        end
        rst = 1'b0;
        n = 0;
        while (!req_ready_a && n < 200) begin
            @(posedge clk); #1;
            n++;
            if (resp_valid_a || resp_valid_b) timeout({tag, "_spurious_resp_valid"});
            if (n == 63) chk({tag, "_init_done_early"}, {31'b0, init_done_a | init_done_b}, 0);
        end
        if (n >= 200) timeout({tag, "_init"});
        chk({tag, "_init_cycles"}, n, 64);
        chk({tag, "_init_done_a"}, {31'b0, init_done_a}, 1);
        chk({tag, "_ready_b"}, {30'b0, req_ready_b, init_done_b}, 3);
        model_init();
    endtask

    task automatic access(input string tag, input logic we, input logic [1:0] size,
                          input logic uns, input logic [31:0] addr, input logic [31:0] wdata,
                          output logic err_a, output logic [31:0] rd_a,
                          output logic err_b, output logic [31:0] rd_b);
        int n, lat_a, lat_b, pulses_a, pulses_b;
        n = 0;
        while (!(req_ready_a && req_ready_b) && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 100) timeout({tag, "_ready_wait"});
        req_valid = 1'b1; req_we = we; req_size = size; req_unsigned = uns;
        req_addr = addr; req_wdata = wdata;
        @(posedge clk); #1;
        req_valid = 1'b0;
        req_we = 1'($urandom); req_size = 2'($urandom); req_unsigned = 1'($urandom);
        req_addr = $urandom; req_wdata = $urandom;
        chk({tag, "_busy_not_ready"}, {30'b0, req_ready_a, req_ready_b}, 0);
        lat_a = 0; lat_b = 0; pulses_a = 0; pulses_b = 0;
        err_a = 1'b0; rd_a = '0; err_b = 1'b0; rd_b = '0;
        for (int c = 1; c <= 6; c++) begin
            @(posedge clk); #1;
            if (resp_valid_a) begin pulses_a++; lat_a = c; err_a = resp_err_a; rd_a = resp_rdata_a; end
            if (resp_valid_b) begin pulses_b++; lat_b = c; err_b = resp_err_b; rd_b = resp_rdata_b; end
        end
        chk({tag, "_latency_a"}, lat_a, 2);
        chk({tag, "_latency_b"}, lat_b, 1);
        chk({tag, "_pulses"}, {pulses_a[15:0], pulses_b[15:0]}, 32'h0001_0001);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic        ea, eb, me;
        logic [31:0] ra, rb, mr;
        logic [1:0]  sz;
        logic [31:0] ad;

        vq.push_back(mk(0, 2, 0, 32'h00, 0, 0, 32'h00000001));
        vq.push_back(mk(0, 2, 0, 32'hFC, 0, 0, 32'h00000001));
        vq.push_back(mk(1, 2, 0, 32'h10, 32'hDEADBEEF, 0, 32'h0));
        vq.push_back(mk(0, 2, 0, 32'h10, 0, 0, 32'hDEADBEEF));
        vq.push_back(mk(1, 0, 0, 32'h21, 32'hFFFFFF80, 0, 32'h0));
        vq.push_back(mk(1, 1, 0, 32'h22, 32'h1234F00D, 0, 32'h0));
        vq.push_back(mk(0, 2, 0, 32'h20, 0, 0, 32'hF00D8001));
        vq.push_back(mk(0, 0, 0, 32'h21, 0, 0, 32'hFFFFFF80));
        vq.push_back(mk(0, 0, 1, 32'h21, 0, 0, 32'h00000080));
        vq.push_back(mk(0, 1, 0, 32'h22, 0, 0, 32'hFFFFF00D));
        vq.push_back(mk(0, 1, 1, 32'h22, 0, 0, 32'h0000F00D));
        vq.push_back(mk(0, 1, 0, 32'h10, 0, 0, 32'hFFFFBEEF));
        vq.push_back(mk(0, 0, 1, 32'h13, 0, 0, 32'h000000DE));
        vq.push_back(mk(0, 2, 1, 32'h10, 0, 0, 32'hDEADBEEF));
        vq.push_back(mk(0, 2, 0, 32'h13, 0, 1, 32'h0));
        vq.push_back(mk(1, 1, 0, 32'h11, 32'h0000AAAA, 1, 32'h0));
        vq.push_back(mk(0, 2, 0, 32'h10, 0, 0, 32'hDEADBEEF));
        vq.push_back(mk(1, 3, 0, 32'h20, 32'h55555555, 1, 32'h0));
        vq.push_back(mk(0, 2, 0, 32'h20, 0, 0, 32'hF00D8001));
        vq.push_back(mk(1, 2, 0, 32'h100, 32'hCAFEF00D, 1, 32'h0));
        vq.push_back(mk(0, 2, 0, 32'h00, 0, 0, 32'h00000001));

        reset_and_init("por");

        foreach (vq[i]) begin
            access($sformatf("vec%0d", i), vq[i].we, vq[i].size, vq[i].uns, vq[i].addr,
                   vq[i].wdata, ea, ra, eb, rb);
            chk($sformatf("vec%0d_err_a", i), {31'b0, ea}, {31'b0, vq[i].err});
            chk($sformatf("vec%0d_rdata_a", i), ra, vq[i].rdata);
            chk($sformatf("vec%0d_err_b", i), {31'b0, eb}, {31'b0, vq[i].err});
            chk($sformatf("vec%0d_rdata_b", i), rb, vq[i].rdata);
            model(vq[i].we, vq[i].size, vq[i].uns, vq[i].addr, vq[i].wdata, me, mr);
        end

        // Reset while a store to 0x08 is in flight: no response, word reinitialised.
        while (!(req_ready_a && req_ready_b)) begin @(posedge clk); #1; end
        req_valid = 1'b1; req_we = 1'b1; req_size = 2'd2; req_unsigned = 1'b0;
        req_addr = 32'h08; req_wdata = 32'h12345678;
        @(posedge clk); #1;
        req_valid = 1'b0;
        reset_and_init("midstore");
        access("midstore_ld08", 0, 2, 0, 32'h08, 0, ea, ra, eb, rb);
        chk("midstore_ld08_a", ra, 32'h00000001);
        chk("midstore_ld08_b", rb, 32'h00000001);
        access("midstore_ld10", 0, 2, 0, 32'h10, 0, ea, ra, eb, rb);
        chk("midstore_ld10_a", ra, 32'h00000001);
        chk("midstore_ld10_b", rb, 32'h00000001);

        // Reset during INIT restarts the fill from word 0.
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        reset_and_init("reinit");

        for (int i = 0; i < 200; i++) begin
            sz = 2'($urandom_range(0, 3));
            ad = 32'($urandom_range(0, 271));
            if ($urandom_range(0, 3) != 0 && sz != 2'd3) ad = ad & ~((32'd1 << sz) - 1);
            req_wdata = $urandom;
            begin
                logic        we_r, uns_r;
                logic [31:0] wd_r;
                we_r = 1'($urandom); uns_r = 1'($urandom); wd_r = $urandom;
                model(we_r, sz, uns_r, ad, wd_r, me, mr);
                access($sformatf("rnd%0d", i), we_r, sz, uns_r, ad, wd_r, ea, ra, eb, rb);
                chk($sformatf("rnd%0d_a", i), {ea, ra[30:0]} ^ {1'b0, ra[31], 30'b0} , {me, mr[30:0]} ^ {1'b0, mr[31], 30'b0});
                chk($sformatf("rnd%0d_rdata_a", i), ra, mr);
                chk($sformatf("rnd%0d_err_b", i), {31'b0, eb}, {31'b0, me});
                chk($sformatf("rnd%0d_rdata_b", i), rb, mr);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/data_memory_bus.md
# data_memory_bus

Parametrised, handshaked data memory for the MIPS datapath, replacing the fixed 64-word, single-cycle data memory. It supports byte, halfword and word accesses on a byte address, with sign or zero extension on loads. It adds configurable wait states to model slower memory, and it clears every word to a known value after reset. The block sits between the MEM-stage load/store unit and the memory array. The pipeline stalls on `req_ready` and `resp_valid`.

## Interface
- `DEPTH`, default 64: number of 32-bit words; must be ≥2. `AW = $clog2(DEPTH)`.
- `WAIT_STATES`, default 1: extra cycles between request acceptance and the access; 0 is legal.
- `INIT_VALUE`, default 32'h00000001: value written to every word during reset initialisation.
- `clk` in 1: single clock, all logic on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `req_valid` in 1: request present.
- `req_ready` out 1: block can accept a request this cycle.
- `req_we` in 1: 1 = store, 0 = load.
- `req_size` in 2: 00 byte, 01 halfword, 10 word, 11 reserved.
- `req_unsigned` in 1: loads only; 1 = zero-extend, 0 = sign-extend.
- `req_addr` in 32: byte address.
- `req_wdata` in 32: store data, right-aligned (byte in [7:0], half in [15:0]).
- `resp_valid` out 1: one-cycle response pulse.
- `resp_rdata` out 32: extended load data; 0 for stores and errors.
- `resp_err` out 1: qualified by `resp_valid`; access was rejected.
- `init_done` out 1: high once initialisation has completed.

## Operation
- **States:** INIT, IDLE, BUSY, RESP.
- **INIT:**
  - Entered on any cycle with `rst`=1, regardless of the current state.
  - An index counter writes `INIT_VALUE` to words 0..DEPTH-1, one word per cycle.
  - After word DEPTH-1 is written, go to IDLE and set `init_done`=1. `init_done` stays high until the next reset.
- **IDLE:**
  - `req_ready`=1.
  - On `req_valid`&&`req_ready`, latch we/size/unsigned/addr/wdata, load the wait counter with `WAIT_STATES`, and go to BUSY.
- **BUSY:**
  - `req_ready`=0.
  - If the counter ≠0, decrement it.
  - If the counter =0, perform the access on this edge and go to RESP.
- **RESP:**
  - `resp_valid`=1 for exactly one cycle.
  - Next edge returns to IDLE. There is no response backpressure.
- **Word index:** `req_addr[AW+1:2]`; byte lane is `req_addr[1:0]`. Byte order is little-endian: lane 0 = bits [7:0].
- **Error checks:** the access is an error, with no memory change, `resp_err`=1 and `resp_rdata`=0, if any of the following holds:
  - `req_size`=11.
  - Halfword with `addr[0]`=1.
  - Word with `addr[1:0]`≠0.
  - `addr[31:2]` ≥ DEPTH (out of range).
- **Stores:**
  - Only the addressed lane(s) change.
  - Byte: `wdata[7:0]` goes to lane `addr[1:0]`.
  - Half: `wdata[15:0]` goes to lanes `addr[1]*2` +1..0.
  - Word: full overwrite.
- **Loads:**
  - Extract the lane(s), then extend to 32 bits according to `req_unsigned`.
  - Word loads ignore `req_unsigned`.
- **Input stability:** request inputs are don't-care outside the acceptance cycle, because the latched copies are used.

## Timing
- **Reset values:**
  - `req_ready`=0, `resp_valid`=0, `resp_rdata`=0, `resp_err`=0, `init_done`=0.
  - State INIT, index counter 0.
- **Init duration:** the first edge with `rst`=0 writes word 0. `req_ready` first rises DEPTH cycles after reset deasserts.
- **Latency:**
  - Acceptance at edge E0; access at edge E(WAIT_STATES+1).
  - `resp_valid` is high in the cycle following that edge.
  - `req_ready` is high again one cycle later.
  - Throughput is one access per WAIT_STATES+3 cycles.
- **Write visibility:** a store is committed at its access edge. A load accepted on any later cycle returns the new data.
- **Reset mid-operation:**
  - A store still in BUSY is discarded.
  - A store already committed stays committed but is then overwritten by INIT.
  - A pending `resp_valid` is suppressed.
- **Reset during INIT:** the index restarts at 0.
- **`req_valid` while `req_ready`=0:** ignored. The requester must hold the request until it is accepted.

## Test plan
- **Reset/init:** DEPTH=64, assert `rst` for 2 cycles, then release.
  - `init_done` and `req_ready` rise after exactly 64 cycles.
  - A word load from addr 0x00 and addr 0xFC returns 0x00000001.
- **Word store/load with WAIT_STATES=1:**
  - Store 0xDEADBEEF at 0x10; `resp_valid` appears 3 cycles after acceptance, with `resp_err`=0 and `resp_rdata`=0.
  - Load from 0x10 returns 0xDEADBEEF.
- **Sub-word stores:**
  - Store byte 0x80 at 0x21, then store half 0xF00D at 0x22.
  - Word load from 0x20 returns 0xF00D8001.
- **Sub-word loads:**
  - Signed byte load from 0x21 returns 0xFFFFFF80; unsigned returns 0x00000080.
  - Signed half load from 0x22 returns 0xFFFFF00D; unsigned returns 0x0000F00D.
- **Errors:**
  - Each of the following gives `resp_err`=1, `resp_rdata`=0, and leaves the memory unchanged: word load at 0x13, half store at 0x11, size 11, word store at 0x100 with DEPTH=64.
- **Reset mid-store and WAIT_STATES=0:**
  - Assert `rst` while a store to 0x08 is in BUSY: no `resp_valid`, and after init 0x08 reads 0x00000001.
  - Rerun with WAIT_STATES=0: `resp_valid` appears 2 cycles after acceptance.
